// File: rtl/mult_div_pkg.sv
// Shared constants for the multiply/divide unit and the control unit that
// sequences it: FSM state encodings, the op select codes and the R-type
// funct values for MULT/DIV.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } md_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_booth_step.sv
// One radix-2 Booth iteration on the {A, Q, q-1} accumulator.
// Ports:
//   acc_a_i  [W:0]   upper accumulator A (one guard bit for exact results)
//   q_i      [W-1:0] multiplier / low product half Q
//   qm1_i            the q-1 bit
//   mcand_i  [W:0]   sign-extended multiplicand
//   acc_a_o, q_o, qm1_o  accumulator after add/sub and arithmetic shift
module booth_step #(
    parameter int W = 32
) (
    input  logic [W:0]   acc_a_i,
    input  logic [W-1:0] q_i,
    input  logic         qm1_i,
    input  logic [W:0]   mcand_i,
    output logic [W:0]   acc_a_o,
    output logic [W-1:0] q_o,
    output logic         qm1_o
);

    logic [W:0] sum_s;

    // Add, subtract or keep the multiplicand according to the Booth pair
    always_comb begin
        sum_s = acc_a_i;
        case ({q_i[0], qm1_i})
            2'b01:   sum_s = acc_a_i + mcand_i;
            2'b10:   sum_s = acc_a_i - mcand_i;
            default: sum_s = acc_a_i;
        endcase
    end

    // Arithmetic shift right of the whole {A, Q, q-1} chain
    assign acc_a_o = {sum_s[W], sum_s[W:1]};
    assign q_o     = {sum_s[0], q_i[W-1:1]};
    assign qm1_o   = q_i[0];

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (Booth) / divide (restoring) unit with HI/LO.
// Ports:
//   clk, reset (async, active-low)
//   start, op (0 MULT, 1 DIV), a, b   request, sampled only in IDLE
//   busy       high in every state but IDLE
//   done       one-cycle completion pulse
//   div_zero   pulses with done when a DIV had b == 0
//   hi, lo     result registers (MULT: product halves, DIV: rem / quot)
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e        state_q, state_d;
    logic [WIDTH:0]   acc_a_q, acc_a_d;
    logic [WIDTH-1:0] acc_q_q, acc_q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] divs_q, divs_d;
    logic             op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [WIDTH:0]   booth_a_s;
    logic [WIDTH-1:0] booth_q_s;
    logic             booth_qm1_s;
    logic [WIDTH:0]   r_sh_s, trial_s;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
        neg_val = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        abs_val = x[WIDTH-1] ? neg_val(x) : x;
    endfunction

    booth_step #(.W(WIDTH)) u_booth (
        .acc_a_i (acc_a_q),
        .q_i     (acc_q_q),
        .qm1_i   (qm1_q),
        .mcand_i ({mcand_q[WIDTH-1], mcand_q}),
        .acc_a_o (booth_a_s),
        .q_o     (booth_q_s),
        .qm1_o   (booth_qm1_s)
    );

    // Restoring divide: shift {R, Q} left and trial-subtract |b|
    assign r_sh_s  = {acc_a_q[WIDTH-1:0], acc_q_q[WIDTH-1]};
    assign trial_s = r_sh_s - {1'b0, divs_q};

    // Next-state, datapath and output-pulse decode
    always_comb begin
        state_d = state_q;
        acc_a_d = acc_a_q;
        acc_q_d = acc_q_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        divs_d  = divs_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_neg_d = a[WIDTH-1];
                    b_neg_d = b[WIDTH-1];
                    cnt_d   = {CW{1'b0}};
                    qm1_d   = 1'b0;
                    acc_a_d = {(WIDTH+1){1'b0}};
                    mcand_d = a;
                    divs_d  = abs_val(b);
                    if (op == OP_DIV) begin
                        acc_q_d = abs_val(a);
                        if (b == {WIDTH{1'b0}}) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        acc_q_d = b;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Counter ticks once per iteration; the cycle that sees it at
                // WIDTH performs no arithmetic and just moves on to FINISH.
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q == OP_MULT) begin
                        acc_a_d = booth_a_s;
                        acc_q_d = booth_q_s;
                        qm1_d   = booth_qm1_s;
                    end else if (!trial_s[WIDTH]) begin
                        acc_a_d = trial_s;
                        acc_q_d = {acc_q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_a_d = r_sh_s;
                        acc_q_d = {acc_q_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (op_q == OP_MULT) begin
                    hi_d = acc_a_q[WIDTH-1:0];
                    lo_d = acc_q_q;
                end else begin
                    // Remainder takes the dividend's sign; quotient negative
                    // when the operand signs differ.
                    hi_d = a_neg_q ? neg_val(acc_a_q[WIDTH-1:0]) : acc_a_q[WIDTH-1:0];
                    lo_d = (a_neg_q ^ b_neg_q) ? neg_val(acc_q_q) : acc_q_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_a_q <= {(WIDTH+1){1'b0}};
            acc_q_q <= {WIDTH{1'b0}};
            qm1_q   <= 1'b0;
            mcand_q <= {WIDTH{1'b0}};
            divs_q  <= {WIDTH{1'b0}};
            op_q    <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_a_q <= acc_a_d;
            acc_q_q <= acc_q_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            divs_q  <= divs_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Randomized and directed bench for mult_div against a cycle-timeline
// reference model built from plain 64-bit signed arithmetic.
module tb_mult_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mult_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Reference result {hi, lo}: exact signed product, or truncating signed
    // division with the remainder following the dividend's sign.
    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            return 64'(sx * sy);
        end else begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
    endfunction

    // Timeline model: edge index, pending result and expected outputs
    longint      n_edge;
    bit          m_busy, m_dz;
    longint      m_done_edge, m_idle_edge;
    logic [31:0] pend_hi, pend_lo, exp_hi, exp_lo;
    bit          exp_done, exp_dz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_edge   <= 0;
            m_busy   <= 1'b0;
            m_dz     <= 1'b0;
            exp_hi   <= 32'h0;
            exp_lo   <= 32'h0;
            exp_done <= 1'b0;
            exp_dz   <= 1'b0;
        end else begin
            n_edge   <= n_edge + 1;
            exp_done <= 1'b0;
            exp_dz   <= 1'b0;
            if (m_busy) begin
                if (n_edge == m_done_edge) begin
                    exp_done <= 1'b1;
                    exp_dz   <= m_dz;
                    if (!m_dz) begin
                        exp_hi <= pend_hi;
                        exp_lo <= pend_lo;
                    end
                end
                if (n_edge == m_idle_edge) m_busy <= 1'b0;
            end else if (start) begin
                m_busy <= 1'b1;
                if (op && b == 32'h0) begin
                    m_dz        <= 1'b1;
                    m_done_edge <= n_edge;
                    m_idle_edge <= n_edge + 1;
                    exp_done    <= 1'b1;
                    exp_dz      <= 1'b1;
                end else begin
                    m_dz        <= 1'b0;
                    m_done_edge <= n_edge + 34;
                    m_idle_edge <= n_edge + 35;
                    {pend_hi, pend_lo} <= ref_result(op, a, b);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (reset) begin
            tests++;
            if (busy !== m_busy || done !== exp_done || div_zero !== exp_dz ||
                hi !== exp_hi || lo !== exp_lo) begin
                fails++;
                $display("FAIL cycle@%0t: got busy=%b done=%b dz=%b hi=%h lo=%h, want busy=%b done=%b dz=%b hi=%h lo=%h",
                         $time, busy, done, div_zero, hi, lo, m_busy, exp_done, exp_dz, exp_hi, exp_lo);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Returns number of negedges after the accept edge until done (-1 on timeout)
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_dir(input string name, input logic o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat);
        int k;
        issue(o, x, y);
        wait_done(k);
        check({name, "_lat"}, 64'(k), 64'(elat));
        check({name, "_hi"},  64'(hi), 64'(ehi));
        check({name, "_lo"},  64'(lo), 64'(elo));
        check({name, "_dz"},  64'(div_zero), 64'(edz));
    endtask

    initial begin
        int k;
        logic        ro;
        logic [31:0] ra, rb;

        // Hand-computed pins on the reference arithmetic
        check("model_mul", ref_result(1'b0, 32'd7, 32'hFFFFFFFD), 64'hFFFFFFFF_FFFFFFEB);
        check("model_div", ref_result(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        #2 reset = 1'b1;

        run_dir("mul7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
        run_dir("mulmin2", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34);
        run_dir("mulm1sq", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 34);
        run_dir("div-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_dir("divovf",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
        run_dir("divpre",  1'b1, 32'h7FFFFFFF, 32'h10, 32'hF, 32'h07FFFFFF, 1'b0, 34);
        run_dir("div5/0",  1'b1, 32'd5, 32'd0, 32'hF, 32'h07FFFFFF, 1'b1, 0);
        @(negedge clk);
        check("dz_busy_1cyc", 64'(busy), 64'h0);

        // start pulse during RUN must be ignored
        issue(1'b0, 32'd123, 32'hFFFFFE38);
        k = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
            if (i == 9) begin
                start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ign_lat", 64'(k), 64'd34);
        check("ign_res", {hi, lo}, 64'hFFFFFFFF_FFFF24E8);
        // back-to-back: accepted the cycle after done
        run_dir("b2b", 1'b0, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 34);

        // reset mid-RUN
        issue(1'b0, 32'd1000, 32'd1000);
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_done", 64'(done), 64'h0);
        check("mrst_hilo", {hi, lo}, 64'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (40) @(negedge clk);
        run_dir("mul3x4", 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34);

        // Randomized operations, checked cycle-by-cycle by the model
        for (int t = 0; t < 40; t++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'h1;
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                4: rb = 32'($urandom_range(1, 20));
                default: ra = $urandom;
            endcase
            issue(ro, ra, rb);
            wait_done(k);
            check("rnd_lat", 64'(k), (ro && rb == 32'h0) ? 64'd0 : 64'd34);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
